// File: rtl/ones_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly k set bits, ascending, one word per
// accepted valid/ready transfer. Successor words come from a Gosper step (no divider).
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int NW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    k_in,
  input  logic             d_ready,
  output logic             d_valid,
  output logic [WIDTH-1:0] d_out,
  output logic             d_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NW-1:0]    pat_cnt,
  output logic             state_dbg
);

  localparam int TZW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] top_q;

  logic [WIDTH-1:0] low_word;
  logic [WIDTH-1:0] top_word;
  logic [WIDTH-1:0] lsb;
  logic [WIDTH-1:0] ripple;
  logic [WIDTH-1:0] nxt;
  logic [TZW-1:0]   tz;
  logic             xfer;

  assign state_dbg = state;

  // First word has k ones in the LSBs; final word has k ones in the MSBs.
  assign low_word = ~({WIDTH{1'b1}} << k_in);
  assign top_word = ~({WIDTH{1'b1}} >> k_in);

  always_comb begin
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d_out[i]) tz = TZW'(i);
    end
  end

  // Gosper successor: carry the lowest run of ones up by one position and
  // refill the bits it leaves behind at the bottom of the word.
  assign lsb    = d_out & (~d_out + WIDTH'(1));
  assign ripple = d_out + lsb;
  assign nxt    = ripple | (((d_out ^ ripple) >> 2) >> tz);

  // Handshake: a word moves when d_valid & d_ready are both high at a rising
  // edge; while d_valid is high and d_ready low, d_out and d_last are held.
  assign xfer = d_valid & d_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      d_valid <= 1'b0;
      d_out   <= '0;
      d_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      pat_cnt <= '0;
      top_q   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k_in > CW'(WIDTH)) begin
              err <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              d_valid <= 1'b1;
              d_out   <= low_word;
              d_last  <= (low_word == top_word);
              top_q   <= top_word;
              pat_cnt <= '0;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            pat_cnt <= pat_cnt + NW'(1);
            if (d_last) begin
              state   <= IDLE;
              d_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              d_out  <= nxt;
              d_last <= (nxt == top_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: expected word lists are built by brute-force
// scanning of all 8-bit values and compared transfer by transfer.
module tb_ones_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int NW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CW-1:0]    k_in;
  logic             d_ready;
  logic             d_valid;
  logic [WIDTH-1:0] d_out;
  logic             d_last;
  logic             busy;
  logic             done;
  logic             err;
  logic [NW-1:0]    pat_cnt;
  logic             state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  logic [WIDTH-1:0] exp_q[$];

  ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .NW(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_in(k_in), .d_ready(d_ready),
    .d_valid(d_valid), .d_out(d_out), .d_last(d_last), .busy(busy),
    .done(done), .err(err), .pat_cnt(pat_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(d_valid), 32'd0);
    check({tag, "_out"},   32'(d_out),   32'd0);
    check({tag, "_last"},  32'(d_last),  32'd0);
    check({tag, "_busy"},  32'(busy),    32'd0);
    check({tag, "_done"},  32'(done),    32'd0);
    check({tag, "_err"},   32'(err),     32'd0);
    check({tag, "_cnt"},   32'(pat_cnt), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge after the first word appears.
  task automatic start_k(input int k);
    start = 1'b1;
    k_in  = CW'(k);
    @(negedge clk);
    start = 1'b0;
    check("start_valid", 32'(d_valid), 32'd1);
    check("start_busy",  32'(busy),    32'd1);
    check("start_cnt",   32'(pat_cnt), 32'd0);
    exp_q.delete();
    for (int v = 0; v < (1 << WIDTH); v++)
      if (popcount(WIDTH'(v)) == k) exp_q.push_back(WIDTH'(v));
  endtask

  // Drains exp_q. rand_rdy toggles d_ready; inject_at fires a start(inj_k) at that
  // transfer index; stop_after>0 returns early once that many words moved.
  task automatic consume(input int k, input bit rand_rdy, input int inject_at,
                         input int inj_k, input int stop_after);
    int               popped = 0;
    int               total;
    bit               stall = 1'b0;
    bit               rdy;
    logic [WIDTH-1:0] held = '0;
    logic [WIDTH-1:0] last_pat;
    total    = exp_q.size();
    last_pat = exp_q[exp_q.size()-1];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("valid",  32'(d_valid), 32'd1);
      check("d_out",  32'(d_out),   32'(exp_q[0]));
      check("d_last", 32'(d_last),  32'(exp_q.size() == 1));
      check("popcnt", 32'(popcount(d_out)), 32'(k));
      check("err_run", 32'(err), 32'd0);
      check("pat_cnt", 32'(pat_cnt), 32'(popped));
      if (stall) check("stable", 32'(d_out), 32'(held));
      rdy = rand_rdy ? 1'(($urandom_range(0, 2) != 0)) : 1'b1;
      d_ready = rdy;
      if (popped == inject_at) begin
        start = 1'b1;
        k_in  = CW'(inj_k);
      end else begin
        start = 1'b0;
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        popped++;
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        held  = exp_q[0];
      end
      @(negedge clk);
      start = 1'b0;
      if (stop_after > 0 && popped == stop_after) return;
      if (exp_q.size() == 0) begin
        check("done",     32'(done),    32'd1);
        check("end_valid", 32'(d_valid), 32'd0);
        check("end_busy", 32'(busy),    32'd0);
        check("end_cnt",  32'(pat_cnt), 32'(total));
        check("end_out",  32'(d_out),   32'(last_pat));
        return;
      end
    end
    check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_in = '0; d_ready = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // k=2, always ready: 28 words
    start_k(2);
    check("k2_first", 32'(d_out), 32'h03);
    consume(2, 1'b0, -1, 0, 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);

    // k=0 then k=8, the second start issued in the done cycle
    start_k(0);
    check("k0_last", 32'(d_last), 32'd1);
    consume(0, 1'b0, -1, 0, 0);
    start_k(8);
    check("k8_out", 32'(d_out), 32'hFF);
    consume(8, 1'b0, -1, 0, 0);
    @(negedge clk);

    // k=9 is illegal
    start = 1'b1; k_in = 4'd9;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err),     32'd1);
    check("err_busy",  32'(busy),    32'd0);
    check("err_valid", 32'(d_valid), 32'd0);
    @(negedge clk);
    check("err_once",  32'(err),     32'd0);
    check("err_valid2", 32'(d_valid), 32'd0);

    // k=4 with random back-pressure: 70 words
    start_k(4);
    consume(4, 1'b1, -1, 0, 0);
    d_ready = 1'b0;
    @(negedge clk);

    // k=3 with an ignored restart request at word 10: 56 words
    start_k(3);
    consume(3, 1'b0, 10, 5, 0);
    @(negedge clk);

    // k=4 abandoned by reset after 20 words
    start_k(4);
    consume(4, 1'b0, -1, 0, 20);
    d_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_k(1);
    check("k1_first", 32'(d_out), 32'h01);
    consume(1, 1'b0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
